// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern generator: shared tick prescaler feeding an array of
// per-channel lanes, each configurable as OFF / ON / BLINK / finite BURST.

module led_blinker_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] half_in,
  input  logic [7:0]       count_in,
  output logic             led,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_e;

  mode_e            mode, mode_nx;
  logic [CNT_W-1:0] half, half_nx, phase, phase_nx;
  logic [7:0]       rem, rem_nx;
  logic             led_nx, busy_nx, done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= M_OFF;
      half  <= '0;
      phase <= '0;
      rem   <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      mode  <= mode_nx;
      half  <= half_nx;
      phase <= phase_nx;
      rem   <= rem_nx;
      led   <= led_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // A write wins over a coincident tick; the tick is simply lost for this lane.
  always_comb begin
    mode_nx  = mode;
    half_nx  = half;
    phase_nx = phase;
    rem_nx   = rem;
    led_nx   = led;
    busy_nx  = busy;
    done_nx  = 1'b0;
    if (we) begin
      half_nx  = (half_in == '0) ? CNT_W'(1) : half_in;
      phase_nx = '0;
      rem_nx   = count_in;
      mode_nx  = mode_e'(mode_in);
      led_nx   = (mode_e'(mode_in) != M_OFF);
      busy_nx  = (mode_e'(mode_in) == M_BLINK) || (mode_e'(mode_in) == M_BURST);
      if (mode_e'(mode_in) == M_BURST && count_in == 8'd0) begin
        mode_nx = M_OFF;
        led_nx  = 1'b0;
        busy_nx = 1'b0;
        done_nx = 1'b1;
      end
    end else if (tick && (mode == M_BLINK || mode == M_BURST)) begin
      if (phase == half - CNT_W'(1)) begin
        phase_nx = '0;
        led_nx   = ~led;
        // Each falling edge of a burst closes one full blink.
        if (mode == M_BURST && led) begin
          rem_nx = rem - 8'd1;
          if (rem == 8'd1) begin
            mode_nx = M_OFF;
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end else begin
        phase_nx = phase + CNT_W'(1);
      end
    end
  end
endmodule

module led_blinker_multi #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 16,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic [7:0]          cfg_count,
  output logic [CHANNELS-1:0] led_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) pcnt <= '0;
    else             pcnt <= pcnt + PW'(1);
  end

  // Out-of-range channel indices match no lane and are dropped naturally.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    led_blinker_lane #(.CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .we       (cfg_we && (cfg_ch == CHW'(g))),
      .mode_in  (cfg_mode),
      .half_in  (cfg_half),
      .count_in (cfg_count),
      .led      (led_out[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end
endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench: two instances (TICK_DIV=1 with 3 channels, TICK_DIV=4 with 4),
// expected {led,busy,done} per channel queued per cycle and compared after each edge.

module tb_led_blinker_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, we_a = 1'b0;
  logic [1:0] ch_a = '0, mode_a = '0;
  logic [7:0] half_a = '0, cnt_a = '0;
  logic [2:0] led_a, busy_a, done_a;

  logic       rst_b = 1'b1, we_b = 1'b0;
  logic [1:0] ch_b = '0, mode_b = '0;
  logic [7:0] half_b = '0, cnt_b = '0;
  logic [3:0] led_b, busy_b, done_b;

  led_blinker_multi #(.CHANNELS(3), .TICK_DIV(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst_a), .cfg_we(we_a), .cfg_ch(ch_a), .cfg_mode(mode_a),
    .cfg_half(half_a), .cfg_count(cnt_a), .led_out(led_a), .busy(busy_a), .done(done_a));

  led_blinker_multi #(.CHANNELS(4), .TICK_DIV(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst_b), .cfg_we(we_b), .cfg_ch(ch_b), .cfg_mode(mode_b),
    .cfg_half(half_b), .cfg_count(cnt_b), .led_out(led_b), .busy(busy_b), .done(done_b));

  typedef struct {
    int         cyc;
    bit         on_b;
    int         ch;
    logic [2:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0, errs = 0, checks = 0;

  task automatic push(int rel, bit on_b, int ch, logic l, logic b, logic d);
    exp_t e;
    e.cyc = cyc + rel; e.on_b = on_b; e.ch = ch; e.exp = {l, b, d};
    sbq.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk); #1; cyc++;
    we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic wr_a(int ch, int mode, int half, int cnt);
    we_a = 1'b1; ch_a = 2'(ch); mode_a = 2'(mode); half_a = 8'(half); cnt_a = 8'(cnt);
  endtask

  task automatic wr_b(int ch, int mode, int half, int cnt);
    we_b = 1'b1; ch_b = 2'(ch); mode_b = 2'(mode); half_b = 8'(half); cnt_b = 8'(cnt);
  endtask

  function automatic logic [2:0] act(bit on_b, int ch);
    return on_b ? {led_b[ch], busy_b[ch], done_b[ch]} : {led_a[ch], busy_a[ch], done_a[ch]};
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) push(2, 0, c, 0, 0, 0);
    for (int c = 0; c < 4; c++) push(2, 1, c, 0, 0, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL reset dut%0d ch%0d cyc%0d: got %b want %b", e.on_b, e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  // Prescaler starts from 0 at reset release: first tick lands on the 4th edge.
  task automatic test_prescaler();
    for (int r = 1; r <= 3; r++) push(r, 1, 0, 1, 1, 0);
    for (int r = 4; r <= 7; r++) push(r, 1, 0, 0, 1, 0);
    for (int r = 8; r <= 9; r++) push(r, 1, 0, 1, 1, 0);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        rst_a = 1'b0; rst_b = 1'b0;
        wr_b(0, 2, 1, 0);
      end
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL prescaler ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  task automatic test_on_burst0();
    for (int r = 1; r <= 8; r++) push(r, 1, 2, 1, 0, 0);
    push(1, 1, 3, 0, 0, 0);
    push(2, 1, 3, 0, 0, 1);
    for (int r = 3; r <= 8; r++) push(r, 1, 3, 0, 0, 0);
    // Keep the queue ordered by cycle.
    sbq.sort() with (item.cyc);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) wr_b(2, 1, 5, 0);
      if (k == 1) wr_b(3, 3, 2, 0);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL on_burst0 ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  task automatic test_blink();
    for (int r = 1; r <= 12; r++) push(r, 0, 1, (((r - 1) / 3) % 2) == 0, 1, 0);
    for (int k = 0; k < 12; k++) begin
      if (k == 0) wr_a(1, 2, 3, 0);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL blink ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  task automatic test_burst();
    push(1, 0, 0, 1, 1, 0);
    push(2, 0, 0, 0, 1, 0);
    push(3, 0, 0, 1, 1, 0);
    push(4, 0, 0, 0, 0, 1);
    for (int r = 5; r <= 7; r++) push(r, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      if (k == 0) wr_a(0, 3, 1, 2);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL burst ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  // Restart on the cycle where the old pattern would toggle, then abort, then an
  // out-of-range write that must touch nothing.
  task automatic test_back_to_back();
    push(1, 0, 0, 1, 1, 0);
    push(2, 0, 0, 1, 1, 0);
    push(3, 0, 0, 1, 1, 0);
    push(4, 0, 0, 1, 1, 0);
    push(5, 0, 0, 0, 1, 0);
    push(6, 0, 0, 0, 0, 0);
    for (int r = 7; r <= 8; r++) begin
      push(r, 0, 0, 0, 0, 0);
      push(r, 0, 2, 0, 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 0) wr_a(0, 2, 2, 0);
      if (k == 2) wr_a(0, 2, 2, 0);
      if (k == 5) wr_a(0, 0, 2, 0);
      if (k == 6) wr_a(3, 1, 1, 1);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL back_to_back ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  task automatic test_half0();
    for (int r = 1; r <= 6; r++) push(r, 0, 2, (r % 2) == 1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) wr_a(2, 2, 0, 0);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL half0 ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    push(1, 0, 0, 1, 1, 0);
    push(2, 0, 0, 1, 1, 0);
    push(3, 0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) push(4, 0, c, 0, 0, 0);
    for (int r = 5; r <= 10; r++) push(r, 0, 0, 0, 0, 0);
    push(11, 0, 1, 1, 1, 0);
    push(12, 0, 1, 1, 1, 0);
    push(13, 0, 1, 0, 1, 0);
    push(14, 0, 1, 0, 1, 0);
    for (int k = 0; k < 14; k++) begin
      if (k == 0) wr_a(0, 3, 2, 5);
      if (k == 3) rst_a = 1'b1;
      if (k == 4) rst_a = 1'b0;
      if (k == 10) wr_a(1, 2, 2, 0);
      adv();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (act(e.on_b, e.ch) !== e.exp) begin
          errs++;
          $display("FAIL reset_mid_burst ch%0d cyc%0d: got %b want %b", e.ch, cyc, act(e.on_b, e.ch), e.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_on_burst0();
    test_blink();
    test_burst();
    test_back_to_back();
    test_half0();
    test_reset_mid_burst();
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/led_blinker_multi.md
# led_blinker_multi

Multi-channel, parametrised LED pattern generator that succeeds the single-output toggle blinker. A shared prescaler turns the system clock into a slow tick. Each channel is independently configured over a simple write port as OFF, ON, continuous BLINK, or a finite BURST of N blinks with a completion pulse. The block sits between board-level control logic and the LED pins.

## Interface
- `CHANNELS`, default 4: number of independent LED channels, ≥1.
- `TICK_DIV`, default 1000: clock cycles per prescaler tick, ≥1.
- `CNT_W`, default 16: width of the half-period tick count.
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_we`, in, 1: configuration write strobe, one cycle per write.
- `cfg_ch`, in, max(1,$clog2(CHANNELS)): target channel index.
- `cfg_mode`, in, 2: 0=OFF, 1=ON, 2=BLINK, 3=BURST.
- `cfg_half`, in, CNT_W: ticks per half-period (LED-on time = LED-off time).
- `cfg_count`, in, 8: number of full blinks in BURST mode.
- `led_out`, out, CHANNELS: registered LED drive, bit i = channel i.
- `busy`, out, CHANNELS: channel is in BLINK or an unfinished BURST.
- `done`, out, CHANNELS: one-cycle pulse when a BURST completes.

## Operation
- Prescaler:
  - Free-running counter 0..TICK_DIV-1, cleared by `rst`.
  - `tick` is high for the one cycle in which the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives `tick` every cycle.
  - `tick` is shared by all channels and is not reset by config writes.
- Per-channel state:
  - `mode` (2b), `half` (CNT_W), `phase` counter (CNT_W), `remaining` (8b), `led`.
- Config write (`cfg_we`=1 and `cfg_ch` < CHANNELS):
  - Loads `mode`, `half`, `remaining` from the inputs and clears `phase` to 0.
  - `cfg_half`=0 is stored as 1.
  - OFF: `led`←0, `busy`←0.
  - ON: `led`←1, `busy`←0.
  - BLINK: `led`←1, `busy`←1.
  - BURST, `cfg_count`≥1: `led`←1, `busy`←1.
  - BURST, `cfg_count`=0: `led`←0, `busy`←0, `done` pulses the next cycle, and the mode is stored as OFF.
  - A write with `cfg_ch` ≥ CHANNELS is ignored.
- Tick (BLINK/BURST channels only):
  - If `phase`==`half`-1: `phase`←0 and `led` toggles.
  - Otherwise `phase`++.
- BURST completion:
  - Each 1→0 toggle decrements `remaining`.
  - On the toggle that brings `remaining` to 0, in the same edge: `led`←0, mode←OFF, `busy`←0, `done`←1 for exactly one cycle.
- OFF/ON channels ignore ticks.
- A write to channel i in the same cycle as a tick takes priority for channel i; that tick is discarded for i only. Other channels process the tick normally.
- Rewriting a busy channel aborts the current pattern immediately with no `done` pulse and restarts from the new config.
- Reset values:
  - `led_out`=0, `busy`=0, `done`=0.
  - All modes OFF; `phase`, `remaining` and prescaler = 0.
  - `rst` mid-pattern aborts with no `done` pulse.

## Timing
- Config write at edge E0: `led_out`/`busy` reflect the new mode after E0, so latency is 1 cycle.
- BLINK period is 2·`half`·TICK_DIV cycles.
- The first half-period after a write is shortened by the prescaler phase: 0..TICK_DIV-1 cycles.
- With TICK_DIV=1, the first half-period is exactly `half` cycles.
- `done` is high for exactly one cycle, coincident with the first cycle of final `led`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counters wrap only via the `half`-1 compare. `phase` never exceeds `half`-1.

## Test plan
- Reset mid-BURST (TICK_DIV=1, ch0 BURST half=2 count=5), assert `rst` for 1 cycle at cycle 3 → `led_out`=0, `busy`=0, `done` never pulses; prescaler restarts at 0.
- TICK_DIV=1, write ch1 BLINK half=3 → `led_out[1]` high 3 cycles, low 3, repeating. `busy[1]`=1 throughout. `done[1]` never asserts.
- TICK_DIV=1, write ch0 BURST half=1 count=2 at E0 → `led_out[0]`=1,0,1,0 after E0..E3. `done[0]`=1 only after E3. `busy[0]` falls after E3.
- TICK_DIV=4, write ch2 ON then ch3 BURST count=0 → `led_out[2]`=1 constant. `led_out[3]`=0, `busy[3]`=0, one-cycle `done[3]` the cycle after the write.
- TICK_DIV=1, ch0 BLINK half=2 running, rewrite ch0 OFF on the same cycle as a tick; write `cfg_ch`=CHANNELS → ch0 `led`=0 and `busy`=0 next cycle; the out-of-range write changes nothing.
- TICK_DIV=1, BLINK with `cfg_half`=0 → behaves as half=1, toggling every cycle.
